// File: rtl/imem_boot_loader_if.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_if
// Byte-stream input (valid/ready) and instruction-memory write port of the
// boot loader, bundled so the loader and its environment share one port.
//   master : stream source / memory side (drives the byte stream)
//   slave  : the loader (accepts bytes, drives the memory write port)
// -----------------------------------------------------------------------------
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [15:0]       im_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Loads 16-bit instruction words, sent as a length byte followed by high/low
// byte pairs, into instruction memory and holds the CPU in reset until the
// load has completed.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a trailing XOR checksum byte is expected after the last word;
//   a mismatch ends the load in ERR with the CPU still held in reset.
//   When undefined, the last write goes straight to DONE and err is tied low.
// -----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_boot_loader_if.slave    bus,
    input  logic                 reload,
    output logic                 cpu_reset,
    output logic                 done,
    output logic                 err
);

    // Remaining-word count needs one extra bit so a full-depth load fits.
    localparam logic [ADDR_W:0] FULL_LOAD = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_LEN,
        S_HI,
        S_LO,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remaining_q;
    logic [7:0]        hi_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [15:0]       im_wdata_q;

    logic              ready_c;
    logic              we_c;
    logic              done_c;
    logic              err_c;
    logic              cpu_reset_c;
    logic              accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    // A byte moves only when the loader is ready and the source is valid.
    assign accept = ready_c & bus.in_valid;

    // State register; an asserted reset aborts any load in progress at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LEN;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples the pre-edge value of every other flop.
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs (no input-to-output paths).
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d     = state_q;
        ready_c     = 1'b0;
        we_c        = 1'b0;
        done_c      = 1'b0;
        err_c       = 1'b0;
        cpu_reset_c = 1'b1;

        unique case (state_q)
            S_LEN: begin
                ready_c = 1'b1;
                if (bus.in_valid) state_d = S_HI;
            end
            S_HI: begin
                ready_c = 1'b1;
                if (bus.in_valid) state_d = S_LO;
            end
            S_LO: begin
                ready_c = 1'b1;
                if (bus.in_valid) state_d = S_WRITE;
            end
            S_WRITE: begin
                we_c = 1'b1;
                if (remaining_q == LAST_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_HI;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: begin
                done_c      = 1'b1;
                cpu_reset_c = 1'b0;
                if (reload) state_d = S_LEN;
            end
            S_ERR: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                err_c = 1'b1;
`endif
                if (reload) state_d = S_LEN;
            end
            default: state_d = S_LEN;
        endcase
    end

    // Word assembly, write-address tracking and remaining-word count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
            hi_q        <= 8'h00;
            im_addr_q   <= '0;
            im_wdata_q  <= 16'h0000;
        end else begin
            case (state_q)
                S_LEN: begin
                    if (accept) begin
                        remaining_q <= (bus.in_data == 8'h00) ? FULL_LOAD
                                                              : (ADDR_W+1)'(bus.in_data);
                        addr_q      <= '0;
                    end
                end
                S_HI: begin
                    if (accept) hi_q <= bus.in_data;
                end
                S_LO: begin
                    if (accept) begin
                        im_wdata_q <= {hi_q, bus.in_data};
                        im_addr_q  <= addr_q;
                    end
                end
                S_WRITE: begin
                    // After the final word of a full-depth load addr_q wraps,
                    // but it is reloaded before it is used again.
                    addr_q      <= addr_q + ADDR_W'(1);
                    remaining_q <= remaining_q - LAST_WORD;
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over payload bytes only; cleared whenever a new load starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= 8'h00;
        end else if ((state_q == S_DONE || state_q == S_ERR) && reload) begin
            csum_q <= 8'h00;
        end else if (accept && (state_q == S_HI || state_q == S_LO)) begin
            csum_q <= csum_q ^ bus.in_data;
        end
    end
`endif

    assign bus.in_ready = ready_c;
    assign bus.im_we    = we_c;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign cpu_reset    = cpu_reset_c;
    assign done         = done_c;
    assign err          = err_c;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
// Drives length-prefixed byte streams (with random valid gaps) into the loader
// and compares every cycle against a stream-level model: which bytes have been
// consumed, which word is due to be written, and whether the load has ended.
// Build with +define+IMEM_LOADER_CHECKSUM_EN for the checksum variant.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

    typedef logic [7:0] byte_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    localparam int M_LOAD = 0;
    localparam int M_DONE = 1;
    localparam int M_ERR  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reload = 1'b0;
    logic cpu_reset;
    logic done;
    logic err;

    imem_boot_loader_if #(.ADDR_W(8)) bus ();

    imem_boot_loader #(.ADDR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .reload    (reload),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stream-level reference model ----------------
    byte_t         m_bytes[$];   // bytes consumed in the current load
    int            m_total;      // words announced by the length byte
    int            m_written;    // words already written
    bit            m_pend;       // a completed word is due on the write port
    int            m_status;
    logic [23:0]   wr_log[$];    // {addr, data} of every observed write

    function automatic void model_clear();
        m_bytes.delete();
        m_total   = 0;
        m_written = 0;
        m_pend    = 1'b0;
        m_status  = M_LOAD;
    endfunction

    initial model_clear();

    // Per-cycle compare, then advance the model by what happens at the next edge.
    always @(negedge clk) begin
        bit    exp_ready;
        bit    xfer;
        byte_t x;
        int    n;
        int    w;
        if (reset) model_clear();
        exp_ready = (m_status == M_LOAD) && !m_pend;
        check("in_ready",  bus.in_ready, exp_ready);
        check("im_we",     bus.im_we,    m_pend);
        check("done",      done,         m_status == M_DONE);
        check("err",       err,          m_status == M_ERR);
        check("cpu_reset", cpu_reset,    m_status != M_DONE);
        if (m_pend) begin
            w = m_written;
            check("im_addr",  bus.im_addr,  w[7:0]);
            check("im_wdata", bus.im_wdata, {m_bytes[1+2*w], m_bytes[2+2*w]});
        end
        if (bus.im_we) wr_log.push_back({bus.im_addr, bus.im_wdata});

        if (!reset) begin
            xfer = bus.in_valid && exp_ready;
            if (m_pend) begin
                m_pend = 1'b0;
                m_written++;
                if (m_written == m_total && !CSUM_EN) m_status = M_DONE;
            end else if (xfer) begin
                m_bytes.push_back(bus.in_data);
                n = m_bytes.size();
                if (n == 1) begin
                    m_total = (bus.in_data == 8'h00) ? 256 : int'(bus.in_data);
                end else if (n - 1 <= 2 * m_total) begin
                    if ((n - 1) % 2 == 0) m_pend = 1'b1;
                end else begin
                    x = 8'h00;
                    for (int i = 1; i < n - 1; i++) x ^= m_bytes[i];
                    m_status = (x == bus.in_data) ? M_DONE : M_ERR;
                end
            end else if (reload && m_status != M_LOAD) begin
                model_clear();
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic void make_stream(input int n, input bit bad, output byte_t s[$]);
        byte_t x;
        byte_t b;
        x = 8'h00;
        s = {};
        s.push_back(byte_t'(n));
        for (int i = 0; i < 2 * n; i++) begin
            b = byte_t'($urandom);
            s.push_back(b);
            x ^= b;
        end
        if (CSUM_EN) s.push_back(bad ? (x ^ 8'h01) : x);
    endfunction

    // Offers bytes in order, holding each until it is accepted; gap is the
    // percentage of cycles with valid dropped.
    task automatic send_stream(input byte_t s[$], input int gap);
        int i;
        int cyc;
        bit xfer;
        i = 0;
        cyc = 0;
        while (i < s.size() && cyc < 6000) begin
            if (gap > 0 && $urandom_range(99) < gap) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = s[i];
            end
            @(negedge clk);
            xfer = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (xfer) i++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream_consumed", i, s.size());
    endtask

    task automatic wait_finish();
        int c;
        c = 0;
        while (!(done || err) && c < 64) begin
            @(negedge clk);
            c++;
        end
        #1;
        check("finish_reached", done || err, 1'b1);
    endtask

    task automatic do_reload();
        @(posedge clk);
        #1 reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
        check("reload_cpu_reset", cpu_reset,    1'b1);
        check("reload_in_ready",  bus.in_ready, 1'b1);
        check("reload_done",      done,         1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        byte_t s[$];
        int    n;
        bit    bad;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1 reset = 1'b1;
        #2;
        check("rst_in_ready",  bus.in_ready, 1'b1);
        check("rst_im_we",     bus.im_we,    1'b0);
        check("rst_im_addr",   bus.im_addr,  8'h00);
        check("rst_im_wdata",  bus.im_wdata, 16'h0000);
        check("rst_cpu_reset", cpu_reset,    1'b1);
        check("rst_done",      done,         1'b0);
        check("rst_err",       err,          1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Basic load with valid held high (backpressure across WRITE).
        s = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
        if (CSUM_EN) s.push_back(8'h08);
        wr_log.delete();
        send_stream(s, 0);
        wait_finish();
        check("basic_nwrites",  wr_log.size(), 2);
        check("basic_wr0",      wr_log[0], 24'h00_1234);
        check("basic_wr1",      wr_log[1], 24'h01_5678);
        check("basic_done",     done,      1'b1);
        check("basic_cpu_rst",  cpu_reset, 1'b0);

        // Reload from DONE and a second short load.
        do_reload();
        s = '{8'h01, 8'h00, 8'h07};
        if (CSUM_EN) s.push_back(8'h07);
        wr_log.delete();
        send_stream(s, 0);
        wait_finish();
        check("reload_nwrites", wr_log.size(), 1);
        check("reload_wr0",     wr_log[0], 24'h00_0007);

        // Random loads with random valid gaps.
        for (int k = 0; k < 6; k++) begin
            do_reload();
            n   = $urandom_range(1, 12);
            bad = ($urandom_range(3) == 0);
            make_stream(n, bad, s);
            wr_log.delete();
            send_stream(s, 40);
            wait_finish();
            check("rand_nwrites", wr_log.size(), n);
        end

        // Full-depth load (length byte 0).
        do_reload();
        make_stream(256, 1'b0, s);
        wr_log.delete();
        send_stream(s, 15);
        wait_finish();
        check("full_nwrites",  wr_log.size(), 256);
        check("full_first",    wr_log[0][23:16],   8'h00);
        check("full_last",     wr_log[255][23:16], 8'hFF);
        check("full_done",     done, 1'b1);

        // Reset after the first word of a 3-word load has been written.
        do_reload();
        s = '{8'h03, 8'h11, 8'h22, 8'h44};
        wr_log.delete();
        send_stream(s, 0);
        check("midrst_first_wr", wr_log.size(), 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_im_we",     bus.im_we,    1'b0);
        check("midrst_cpu_reset", cpu_reset,    1'b1);
        check("midrst_done",      done,         1'b0);
        check("midrst_in_ready",  bus.in_ready, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        s = '{8'h01, 8'hAB, 8'hCD};
        if (CSUM_EN) s.push_back(8'h66);
        wr_log.delete();
        send_stream(s, 0);
        wait_finish();
        check("midrst_nwrites", wr_log.size(), 1);
        check("midrst_wr0",     wr_log[0], 24'h00_ABCD);
        check("midrst_done2",   done, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match, mismatch, then recovery from ERR.
        do_reload();
        send_stream('{8'h01, 8'h12, 8'h34, 8'h26}, 0);
        wait_finish();
        check("csum_ok_done", done, 1'b1);
        do_reload();
        send_stream('{8'h01, 8'h12, 8'h34, 8'h27}, 0);
        wait_finish();
        check("csum_bad_err",       err,       1'b1);
        check("csum_bad_done",      done,      1'b0);
        check("csum_bad_cpu_reset", cpu_reset, 1'b1);
        do_reload();
        send_stream('{8'h01, 8'h12, 8'h34, 8'h26}, 0);
        wait_finish();
        check("csum_retry_done", done, 1'b1);
        check("csum_retry_err",  err,  1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the 8-bit CPU core.
- Receives a byte stream over a valid/ready interface and assembles 16-bit instruction words.
- Writes those words into instruction memory through a dedicated write port.
- Holds the CPU in reset until the load completes, then releases it so the PC starts fetching from address 0.

Parameters:
- ADDR_W, 8, instruction memory address width; maximum load is 2^ADDR_W words.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  byte-stream valid
- in_data  input  8  byte-stream payload
- in_ready  output  1  loader accepts a byte this cycle
- reload  input  1  single-cycle pulse: restart loading (honoured only in DONE/ERR)
- im_we  output  1  instruction memory write enable
- im_addr  output  ADDR_W  instruction memory write address
- im_wdata  output  16  instruction word to write
- cpu_reset  output  1  active-high reset to the CPU core
- done  output  1  load completed successfully
- err  output  1  load failed (checksum build only)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- State on reset: state = LEN, addr counter = 0, remaining = 0, hi byte reg = 0, checksum = 0.
- Outputs on reset: im_we = 0, im_addr = 0, im_wdata = 0, cpu_reset = 1, done = 0, err = 0, in_ready = 1.
- Transfer rule: a byte is consumed only on a rising edge with in_valid & in_ready. in_valid while in_ready = 0 is ignored; the source holds the byte.
- Stream format: one length byte N, then N instruction words, each sent high byte first. N = 0 means 2^ADDR_W words (256 at default).
- States: LEN, HI, LO, WRITE, CSUM (checksum build only), DONE, ERR.
- LEN: in_ready = 1. On transfer, remaining <= (N == 0 ? 2^ADDR_W : N), addr <= 0, next state HI.
- HI: in_ready = 1. On transfer, latch the hi byte, next state LO.
- LO: in_ready = 1. On transfer, register im_wdata <= {hi, in_data} and im_addr <= addr, next state WRITE.
- WRITE: in_ready = 0, im_we = 1 for exactly this one cycle. Then addr <= addr + 1 and remaining <= remaining - 1.
- WRITE exit: if remaining == 1, go to DONE (or CSUM in the checksum build); otherwise go to HI.
- Throughput: at most one word per 3 cycles. Latency from the LO byte transfer to im_we high is 1 cycle.
- DONE: in_ready = 0, done = 1, cpu_reset = 0 from the first cycle in DONE. Outputs are decoded from the state register only, with no combinational path from inputs.
- ERR: in_ready = 0, err = 1, cpu_reset = 1.
- reload in DONE or ERR: next state LEN; cpu_reset = 1 and done = err = 0 on the following cycle. reload in any other state is ignored.
- Boundaries:
  - addr never wraps within a load; at full-depth load the last write is addr 2^ADDR_W-1.
  - The remaining counter is ADDR_W+1 bits wide.
- Reset mid-load: the abort takes effect immediately. im_we drops asynchronously, cpu_reset = 1, and the next byte is treated as a length byte. Previously written memory contents are not cleared.
- Memory is never written outside the WRITE state.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro:
  - An 8-bit running XOR of all payload bytes is kept; the length byte is excluded.
  - After the last WRITE, the FSM enters CSUM with in_ready = 1 and accepts one checksum byte.
  - Match goes to DONE; mismatch goes to ERR.
  - The checksum register clears on reset and on entry to LEN.
- Without the macro:
  - The CSUM state and XOR logic are absent; WRITE goes directly to DONE.
  - err is tied to 0.

Test Plan:
- Basic load: stream 02,12,34,56,78 with in_valid held high. Expect im_we pulses at (addr 00, 1234) then (01, 5678). Then done = 1 and cpu_reset = 0. In the checksum build, append 08 to the stream.
- Backpressure: hold in_valid = 1 with a new byte across WRITE. Expect in_ready = 0 and the byte not consumed; it is accepted in the next HI cycle. Random valid gaps must still produce identical writes.
- Length 0: send 00 followed by 512 bytes. Expect 256 writes at addr 00..FF, the last im_addr = FF, then DONE.
- Mid-load reset: assert reset after the first word is written. Expect im_we = 0, cpu_reset = 1, done = 0 immediately. Then stream 01,AB,CD and expect a single write (00, ABCD) followed by DONE.
- Reload: pulse reload in DONE. Expect cpu_reset = 1 and in_ready = 1 next cycle. A new stream 01,00,07 writes (00, 0007).
- Checksum (EN build only): stream 01,12,34 then 26 ends in DONE. Stream 01,12,34 then 27 ends in ERR with err = 1 and cpu_reset = 1. Reload from ERR then succeeds.
